// File: rtl/adc_uart_formatter_pkg.sv
// Shared constants, state encoding and line-character helper for the ADC-to-UART formatter.
package adc_uart_formatter_pkg;

  localparam int unsigned LINE_LEN = 13;
  localparam int unsigned MV_W     = 12;  // millivolt value width (0..4095)

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_V     = 8'h56;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_C     = 8'h43;
  localparam logic [7:0] ASCII_H     = 8'h48;

  typedef enum logic [2:0] {StIdle, StSnap, StScale, StDigit, StEmit, StNext} state_e;

  // Character at position idx of "CHnn:d.dddV\r\n".
  function automatic logic [7:0] line_char(input logic [3:0] idx, input logic [3:0] ch_tens,
                                           input logic [3:0] ch_ones, input logic [3:0] d3,
                                           input logic [3:0] d2, input logic [3:0] d1,
                                           input logic [3:0] d0);
    logic [7:0] c;
    c = 8'h00;
    case (idx)
      4'd0:    c = ASCII_C;
      4'd1:    c = ASCII_H;
      4'd2:    c = ASCII_0 + {4'h0, ch_tens};
      4'd3:    c = ASCII_0 + {4'h0, ch_ones};
      4'd4:    c = ASCII_COLON;
      4'd5:    c = ASCII_0 + {4'h0, d3};
      4'd6:    c = ASCII_DOT;
      4'd7:    c = ASCII_0 + {4'h0, d2};
      4'd8:    c = ASCII_0 + {4'h0, d1};
      4'd9:    c = ASCII_0 + {4'h0, d0};
      4'd10:   c = ASCII_V;
      4'd11:   c = ASCII_CR;
      4'd12:   c = ASCII_LF;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/adc_uart_formatter_if.sv
// ADC input bus and UART FIFO write port of the formatter.
interface adc_uart_formatter_if #(
  parameter int unsigned N_CH = 13,
  parameter int unsigned DW   = 12
);
  logic [N_CH*DW-1:0] adc_in;
  logic               enable;
  logic               tx_full;
  logic [7:0]         data;
  logic               wr;
  logic               busy;

  // master: the formatter itself; slave: the surrounding system
  modport master (input adc_in, enable, tx_full, output data, wr, busy);
  modport slave  (output adc_in, enable, tx_full, input data, wr, busy);
endinterface

// File: rtl/adc_uart_formatter_bin2dec_seq.sv
// Sequential binary-to-BCD converter: one subtraction per cycle, 1000s then 100s then 10s.
module bin2dec_seq
  import adc_uart_formatter_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic [MV_W-1:0] i_value,
  output logic            o_done,
  output logic [3:0]      o_d3,
  output logic [3:0]      o_d2,
  output logic [3:0]      o_d1,
  output logic [3:0]      o_d0
);

  logic            r_run, r_done;
  logic [1:0]      r_phase;
  logic [MV_W-1:0] r_rem;
  logic [3:0]      r_d3, r_d2, r_d1;

  logic            w_run_d, w_done_d;
  logic [1:0]      w_phase_d;
  logic [MV_W-1:0] w_rem_d, w_weight;
  logic [3:0]      w_d3_d, w_d2_d, w_d1_d;

  // Decimal weight of the digit currently being extracted
  always_comb begin
    unique case (r_phase)
      2'd0:    w_weight = MV_W'(1000);
      2'd1:    w_weight = MV_W'(100);
      default: w_weight = MV_W'(10);
    endcase
  end

  // Subtract the weight while it fits, else advance to the next digit or finish
  always_comb begin
    w_run_d   = r_run;
    w_done_d  = 1'b0;
    w_phase_d = r_phase;
    w_rem_d   = r_rem;
    w_d3_d    = r_d3;
    w_d2_d    = r_d2;
    w_d1_d    = r_d1;
    if (i_start) begin
      w_run_d   = 1'b1;
      w_phase_d = 2'd0;
      w_rem_d   = i_value;
      w_d3_d    = 4'd0;
      w_d2_d    = 4'd0;
      w_d1_d    = 4'd0;
    end else if (r_run) begin
      if (r_rem >= w_weight) begin
        w_rem_d = r_rem - w_weight;
        unique case (r_phase)
          2'd0:    w_d3_d = r_d3 + 4'd1;
          2'd1:    w_d2_d = r_d2 + 4'd1;
          default: w_d1_d = r_d1 + 4'd1;
        endcase
      end else if (r_phase == 2'd2) begin
        w_run_d  = 1'b0;
        w_done_d = 1'b1;
      end else begin
        w_phase_d = r_phase + 2'd1;
      end
    end
  end

  // Converter state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run   <= 1'b0;
      r_done  <= 1'b0;
      r_phase <= 2'd0;
      r_rem   <= '0;
      r_d3    <= 4'd0;
      r_d2    <= 4'd0;
      r_d1    <= 4'd0;
    end else begin
      r_run   <= w_run_d;
      r_done  <= w_done_d;
      r_phase <= w_phase_d;
      r_rem   <= w_rem_d;
      r_d3    <= w_d3_d;
      r_d2    <= w_d2_d;
      r_d1    <= w_d1_d;
    end
  end

  assign o_done = r_done;
  assign o_d3   = r_d3;
  assign o_d2   = r_d2;
  assign o_d1   = r_d1;
  assign o_d0   = r_rem[3:0];  // remainder is below 10 once the tens pass ends

endmodule

// File: rtl/adc_uart_formatter.sv
// Periodically snapshots all ADC channels and prints one "CHnn:d.dddV\r\n" line per channel.
module adc_uart_formatter
  import adc_uart_formatter_pkg::*;
#(
  parameter int unsigned N_CH         = 13,
  parameter int unsigned DW           = 12,
  parameter int unsigned VREF_MV      = 3300,
  parameter int unsigned FRAME_PERIOD = 65_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_uart_formatter_if.master bus
);

  localparam int unsigned CntW = $clog2(FRAME_PERIOD);
  localparam int unsigned ChW  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PW   = DW + 12;

  logic [CntW-1:0]    r_cnt;
  logic [N_CH*DW-1:0] r_snap;
  state_e             r_state, w_state_d;
  logic [ChW-1:0]     r_ch, w_ch_d;
  logic [3:0]         r_ch_tens, w_ch_tens_d, r_ch_ones, w_ch_ones_d;
  logic [3:0]         r_idx, w_idx_d;
  logic [DW-1:0]      r_code, w_code_d;
  logic               r_busy, w_busy_d;

  logic               w_tick, w_snap_en, w_start, w_wr, w_done;
  logic [PW-1:0]      w_prod;
  logic [MV_W-1:0]    w_mv;
  logic [3:0]         w_d3, w_d2, w_d1, w_d0;

  assign w_tick = (r_cnt == CntW'(FRAME_PERIOD - 1));
  assign w_prod = PW'(r_code) * PW'(VREF_MV);
  assign w_mv   = MV_W'(w_prod >> DW);  // truncating scale to millivolts

  // Free-running frame period counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_cnt <= '0;
    else if (w_tick) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end

  // Snapshot of every channel taken at frame start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           r_snap <= '0;
    else if (w_snap_en) r_snap <= bus.adc_in;
  end

  bin2dec_seq u_bin2dec (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_start),
    .i_value (w_mv),
    .o_done  (w_done),
    .o_d3    (w_d3),
    .o_d2    (w_d2),
    .o_d1    (w_d1),
    .o_d0    (w_d0)
  );

  // Frame sequencing: next state, channel bookkeeping and the FIFO write strobe
  always_comb begin
    w_state_d   = r_state;
    w_ch_d      = r_ch;
    w_ch_tens_d = r_ch_tens;
    w_ch_ones_d = r_ch_ones;
    w_idx_d     = r_idx;
    w_code_d    = r_code;
    w_busy_d    = r_busy;
    w_snap_en   = 1'b0;
    w_start     = 1'b0;
    w_wr        = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_tick && bus.enable) begin
          w_snap_en   = 1'b1;
          w_ch_d      = '0;
          w_ch_tens_d = 4'd0;
          w_ch_ones_d = 4'd1;
          w_busy_d    = 1'b1;
          w_state_d   = StSnap;
        end
      end
      StSnap: begin
        w_code_d  = r_snap[int'(r_ch)*DW +: DW];
        w_state_d = StScale;
      end
      StScale: begin
        w_start   = 1'b1;
        w_state_d = StDigit;
      end
      StDigit: begin
        if (w_done) begin
          w_idx_d   = 4'd0;
          w_state_d = StEmit;
        end
      end
      StEmit: begin
        if (!bus.tx_full) begin
          w_wr = 1'b1;
          if (r_idx == 4'(LINE_LEN - 1)) begin
            w_state_d = StNext;
            // Drop busy together with the final LF so it is low the cycle after
            if (r_ch == ChW'(N_CH - 1)) w_busy_d = 1'b0;
          end else begin
            w_idx_d = r_idx + 4'd1;
          end
        end
      end
      StNext: begin
        if (r_ch == ChW'(N_CH - 1)) begin
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end else begin
          w_ch_d = r_ch + 1'b1;
          // Printed channel number kept in BCD to avoid a divider
          if (r_ch_ones == 4'd9) begin
            w_ch_ones_d = 4'd0;
            w_ch_tens_d = r_ch_tens + 4'd1;
          end else begin
            w_ch_ones_d = r_ch_ones + 4'd1;
          end
          w_state_d = StSnap;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Frame sequencing registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_ch      <= '0;
      r_ch_tens <= 4'd0;
      r_ch_ones <= 4'd0;
      r_idx     <= 4'd0;
      r_code    <= '0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_ch      <= w_ch_d;
      r_ch_tens <= w_ch_tens_d;
      r_ch_ones <= w_ch_ones_d;
      r_idx     <= w_idx_d;
      r_code    <= w_code_d;
      r_busy    <= w_busy_d;
    end
  end

  assign bus.wr   = w_wr;
  assign bus.busy = r_busy;
  assign bus.data = (r_state == StEmit) ?
                    line_char(r_idx, r_ch_tens, r_ch_ones, w_d3, w_d2, w_d1, w_d0) : 8'h00;

endmodule
